// File: rtl/alu_arbiter_if.sv
// Bundles the two request channels, the ALU operand/result wires and the response channel.
// ALU_ARB_LOCK_EN adds the per-port lock inputs.
interface alu_arbiter_if #(
    parameter int unsigned N = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [1:0]   req0_ctrl;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [1:0]   req1_ctrl;
    logic         req1_cin;
`ifdef ALU_ARB_LOCK_EN
    logic         req0_lock;
    logic         req1_lock;
`endif
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic         alu_cin;
    logic [N-1:0] alu_f;
    logic         alu_cout;
    logic         alu_v;
    logic         alu_z;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_f;
    logic [3:0]   rsp_flags;

    // Master: the requesters plus the ALU itself; slave: the arbiter.
    modport master (
`ifdef ALU_ARB_LOCK_EN
        output req0_lock, req1_lock,
`endif
        output req0_valid, req0_a, req0_b, req0_ctrl, req0_cin,
        output req1_valid, req1_a, req1_b, req1_ctrl, req1_cin,
        output alu_f, alu_cout, alu_v, alu_z, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl, alu_cin,
        input  rsp_valid, rsp_id, rsp_f, rsp_flags
    );

    modport slave (
`ifdef ALU_ARB_LOCK_EN
        input  req0_lock, req1_lock,
`endif
        input  req0_valid, req0_a, req0_b, req0_ctrl, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_ctrl, req1_cin,
        input  alu_f, alu_cout, alu_v, alu_z, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl, alu_cin,
        output rsp_valid, rsp_id, rsp_f, rsp_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional feature macro: ALU_ARB_LOCK_EN (sticky grant to the last locked port).
module alu_arbiter #(
    parameter int unsigned N = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e       r_state;
    state_e       w_state_d;
    logic         r_last_grant;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic [1:0]   r_op_ctrl;
    logic         r_op_cin;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_f;
    logic [3:0]   r_rsp_flags;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_accept;
    logic         w_lock_hold;

`ifdef ALU_ARB_LOCK_EN
    logic r_lock;
    logic w_lock_d;

    assign w_lock_hold = r_lock & (r_last_grant ? bus.req1_valid : bus.req0_valid);
    assign w_lock_d    = w_grant1 ? bus.req1_lock : bus.req0_lock;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock <= w_lock_d;
        end
    end
`else
    assign w_lock_hold = 1'b0;
`endif

    // Grants are only offered in IDLE and never while reset is asserted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n && (r_state == StIdle)) begin
            if (w_lock_hold) begin
                w_grant0 = ~r_last_grant;
                w_grant1 = r_last_grant;
            end else if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign w_accept = w_grant0 | w_grant1;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_d = StExec;
            StExec:  w_state_d = StResp;
            StResp:  if (bus.rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctrl    <= 2'b00;
            r_op_cin     <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_f      <= '0;
            r_rsp_flags  <= 4'b0000;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_last_grant <= w_grant1;
                r_rsp_id     <= w_grant1;
                r_op_a       <= w_grant1 ? bus.req1_a    : bus.req0_a;
                r_op_b       <= w_grant1 ? bus.req1_b    : bus.req0_b;
                r_op_ctrl    <= w_grant1 ? bus.req1_ctrl : bus.req0_ctrl;
                r_op_cin     <= w_grant1 ? bus.req1_cin  : bus.req0_cin;
            end
            if (r_state == StExec) begin
                r_rsp_f     <= bus.alu_f;
                r_rsp_flags <= {bus.alu_cout, bus.alu_v, bus.alu_z, bus.alu_f[N-1]};
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.alu_a      = r_op_a;
    assign bus.alu_b      = r_op_b;
    assign bus.alu_ctrl   = r_op_ctrl;
    assign bus.alu_cin    = r_op_cin;
    assign bus.rsp_valid  = (r_state == StResp);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_f      = r_rsp_f;
    assign bus.rsp_flags  = r_rsp_flags;
endmodule
